// File: rtl/heap_arbiter.sv
// heap_arbiter: round-robin arbiter that shares one single-port heap memory
// between NReq requesters. It accepts one read or write per cycle and drives
// the heap command from registers. Read data comes back to the issuing
// requester two edges after accept, as a one-hot respValid strobe.
//
// Optional feature: define HEAP_ARBITER_BOUNDS_EN to enable the HEAP_LIMIT
// bounds check. Out-of-range commands are accepted, but the memory is not
// written, and the response carries respError=1 with respOut=0. If the macro
// is undefined, addresses pass through unchecked and respError is always 0.
module heap_arbiter #(
  parameter int NReq          = 3,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int HEAP_LIMIT    = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NReq-1:0]               reqValid,
  input  logic [NReq-1:0]               reqWrite,
  input  logic [NReq*ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [NReq*DATA_WIDTH-1:0]    reqIn,
  output logic [NReq-1:0]               reqReady,
  output logic [NReq-1:0]               respValid,
  output logic [DATA_WIDTH-1:0]         respOut,
  output logic                          respError,
  output logic                          heapWrite,
  output logic [ADDRESS_WIDTH-1:0]      heapAddress,
  output logic [DATA_WIDTH-1:0]         heapIn,
  input  logic [DATA_WIDTH-1:0]         heapOut
);

  localparam int IDW = (NReq > 1) ? $clog2(NReq) : 1;

  // Round-robin pointer: the most recently accepted requester.
  logic [IDW-1:0] ptr;

  // Arbitration result.
  logic [NReq-1:0] grant;
  logic            found;
  logic [IDW-1:0]  gid;
  logic [IDW-1:0]  idx;

  // Fields of the granted requester.
  logic                     accept;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     sel_write;
  logic                     oob;

  // Two-stage tag pipeline: {valid, requester id, error}.
  logic           t1_valid;
  logic [IDW-1:0] t1_id;
  logic           t1_err;
  logic           t2_valid;
  logic [IDW-1:0] t2_id;
  logic           t2_err;

  // Scan ptr+1, ptr+2, ... modulo NReq and pick the first valid requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gid   = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NReq; i++) begin
      idx = IDW'((32'(ptr) + i) % 32'(NReq));
      if (!found && reqValid[idx]) begin
        found      = 1'b1;
        gid        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Grant is zero-latency from reqValid but is suppressed while in reset.
  assign reqReady = reset ? grant : '0;
  assign accept   = reset && found;

  // Select the command fields of the granted requester.
  always_comb begin
    sel_addr  = reqAddress[gid*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    sel_data  = reqIn[gid*DATA_WIDTH +: DATA_WIDTH];
    sel_write = reqWrite[gid];
  end

`ifdef HEAP_ARBITER_BOUNDS_EN
  // Flag addresses outside the populated part of the heap.
  assign oob = (32'(sel_addr) >= 32'(HEAP_LIMIT));
`else
  // No bounds check in this build; the limit is carried for interface parity.
  logic unused_limit;
  assign unused_limit = (32'(HEAP_LIMIT) == 32'd0);
  assign oob          = 1'b0;
`endif

  // Register the heap command and advance the round-robin pointer on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr         <= IDW'(NReq - 1);
      heapWrite   <= 1'b0;
      heapAddress <= '0;
      heapIn      <= '0;
    end else begin
      heapWrite <= accept && sel_write && !oob;
      if (accept) begin
        ptr         <= gid;
        heapAddress <= sel_addr;
        heapIn      <= sel_data;
      end
    end
  end

  // Carry the requester tag alongside the memory access to its response cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t1_valid <= 1'b0;
      t1_id    <= '0;
      t1_err   <= 1'b0;
      t2_valid <= 1'b0;
      t2_id    <= '0;
      t2_err   <= 1'b0;
    end else begin
      t1_valid <= accept;
      t1_id    <= gid;
      t1_err   <= accept && oob;
      t2_valid <= t1_valid;
      t2_id    <= t1_id;
      t2_err   <= t1_valid && t1_err;
    end
  end

  // Decode the response tag into a one-hot strobe and pass read data through.
  always_comb begin
    respValid = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      respValid[i] = t2_valid && (t2_id == IDW'(i));
    end
    respError = t2_valid && t2_err;
    respOut   = (t2_valid && !t2_err) ? heapOut : '0;
  end

endmodule

// File: tb/tb_heap_arbiter.sv
// Testbench for heap_arbiter: table-driven cycle vectors plus hand-written
// sequences for reset, bounds handling and reset during an in-flight read.
module tb_heap_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 12;
`ifdef HEAP_ARBITER_BOUNDS_EN
  localparam bit BND = 1'b1;
`else
  localparam bit BND = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic [N-1:0]    reqValid;
  logic [N-1:0]    reqWrite;
  logic [N*AW-1:0] reqAddress;
  logic [N*DW-1:0] reqIn;
  logic [N-1:0]    reqReady;
  logic [N-1:0]    respValid;
  logic [DW-1:0]   respOut;
  logic            respError;
  logic            heapWrite;
  logic [AW-1:0]   heapAddress;
  logic [DW-1:0]   heapIn;
  logic [DW-1:0]   heapOut;

  int n_tests = 0;
  int n_fail  = 0;

  heap_arbiter #(
    .NReq(N),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .HEAP_LIMIT(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .reqValid(reqValid),
    .reqWrite(reqWrite),
    .reqAddress(reqAddress),
    .reqIn(reqIn),
    .reqReady(reqReady),
    .respValid(respValid),
    .respOut(respOut),
    .respError(respError),
    .heapWrite(heapWrite),
    .heapAddress(heapAddress),
    .heapIn(heapIn),
    .heapOut(heapOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port heap memory: registered read, echoes write data on write.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    heapOut = '0;
  end
  always @(posedge clock) begin
    if (heapWrite) mem[heapAddress] <= heapIn;
    heapOut <= heapWrite ? heapIn : mem[heapAddress];
  end

  typedef struct {
    logic [2:0]  v;
    logic [2:0]  w;
    logic [11:0] a0, a1, a2;
    logic [11:0] d0, d1, d2;
    logic [2:0]  exp_ready;
    logic [2:0]  exp_rv;
    logic [11:0] exp_out;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] w,
                       input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                       input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2);
    reqValid   = v;
    reqWrite   = w;
    reqAddress = {a2, a1, a0};
    reqIn      = {d2, d1, d0};
  endtask

  task automatic idle();
    drive(3'b000, 3'b000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] w,
                              input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                              input logic [11:0] d0, input logic [11:0] d1, input logic [11:0] d2,
                              input logic [2:0] er, input logic [2:0] erv, input logic [11:0] eo);
    vec_t r;
    r.v = v; r.w = w; r.a0 = a0; r.a1 = a1; r.a2 = a2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.exp_ready = er; r.exp_rv = erv; r.exp_out = eo;
    return r;
  endfunction

  initial begin
    // Each row is one cycle. Responses in a row belong to the accept two rows earlier.
    tbl[0]  = mk(3'b111, 3'b111, 10, 11, 12, 100, 101, 102, 3'b001, 3'b000, 0);
    tbl[1]  = mk(3'b111, 3'b110, 10, 11, 12, 100, 101, 102, 3'b010, 3'b000, 0);
    tbl[2]  = mk(3'b111, 3'b100, 10, 11, 12, 100, 101, 102, 3'b100, 3'b001, 100);
    tbl[3]  = mk(3'b111, 3'b000, 10, 11, 12, 100, 101, 102, 3'b001, 3'b010, 101);
    tbl[4]  = mk(3'b111, 3'b000, 10, 11, 12, 100, 101, 102, 3'b010, 3'b100, 102);
    tbl[5]  = mk(3'b111, 3'b000, 10, 11, 12, 100, 101, 102, 3'b100, 3'b001, 100);
    tbl[6]  = mk(3'b010, 3'b010, 10,  5, 12, 100, 333, 102, 3'b010, 3'b010, 101);
    tbl[7]  = mk(3'b010, 3'b000, 10,  5, 12, 100, 333, 102, 3'b010, 3'b100, 102);
    tbl[8]  = mk(3'b000, 3'b000,  0,  0,  0,   0,   0,   0, 3'b000, 3'b010, 333);
    tbl[9]  = mk(3'b000, 3'b000,  0,  0,  0,   0,   0,   0, 3'b000, 3'b010, 333);
    tbl[10] = mk(3'b001, 3'b000, 10,  0,  0,   0,   0,   0, 3'b001, 3'b000, 0);
    tbl[11] = mk(3'b110, 3'b000,  0, 11, 12,   0,   0,   0, 3'b010, 3'b000, 0);
    tbl[12] = mk(3'b000, 3'b000,  0,  0,  0,   0,   0,   0, 3'b000, 3'b001, 100);
    tbl[13] = mk(3'b000, 3'b000,  0,  0,  0,   0,   0,   0, 3'b000, 3'b010, 101);
    tbl[14] = mk(3'b000, 3'b000,  0,  0,  0,   0,   0,   0, 3'b000, 3'b000, 0);

    // Reset held low with every requester asking.
    reset = 1'b0;
    drive(3'b111, 3'b111, 1, 2, 3, 4, 5, 6);
    cyc(); cyc(); cyc();
    chk("rst reqReady",    32'(reqReady), 0);
    chk("rst respValid",   32'(respValid), 0);
    chk("rst respError",   32'(respError), 0);
    chk("rst respOut",     32'(respOut), 0);
    chk("rst heapWrite",   32'(heapWrite), 0);
    chk("rst heapAddress", 32'(heapAddress), 0);
    chk("rst heapIn",      32'(heapIn), 0);
    reset = 1'b1;

    // Round-robin, write-then-read, withdrawn request.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, tbl[i].a2,
            tbl[i].d0, tbl[i].d1, tbl[i].d2);
      #2;
      chk($sformatf("row%0d reqReady", i),  32'(reqReady),  32'(tbl[i].exp_ready));
      chk($sformatf("row%0d respValid", i), 32'(respValid), 32'(tbl[i].exp_rv));
      chk($sformatf("row%0d respOut", i),   32'(respOut),   32'(tbl[i].exp_out));
      chk($sformatf("row%0d respError", i), 32'(respError), 0);
      cyc();
    end

    // Address 20 is beyond a HEAP_LIMIT of 16: write 111, then read it back.
    drive(3'b100, 3'b100, 0, 0, 20, 0, 0, 111);
    #2 chk("bnd wr reqReady", 32'(reqReady), 32'(3'b100));
    cyc();
    drive(3'b100, 3'b000, 0, 0, 20, 0, 0, 0);
    #2 chk("bnd heapWrite", 32'(heapWrite), BND ? 0 : 1);
    chk("bnd rd reqReady", 32'(reqReady), 32'(3'b100));
    cyc();
    idle();
    #2 chk("bnd wr respValid", 32'(respValid), 32'(3'b100));
    chk("bnd wr respError", 32'(respError), BND ? 1 : 0);
    chk("bnd wr respOut",   32'(respOut),   BND ? 0 : 111);
    cyc();
    #2 chk("bnd rd respValid", 32'(respValid), 32'(3'b100));
    chk("bnd rd respError", 32'(respError), BND ? 1 : 0);
    chk("bnd rd respOut",   32'(respOut),   BND ? 0 : 111);
    chk("bnd mem[20]",      32'(mem[20]),   BND ? 0 : 111);
    cyc();

    // Store 77 at address 7, then reset while a read of it is in flight.
    drive(3'b001, 3'b001, 7, 0, 0, 77, 0, 0);
    #2 chk("mid wr reqReady", 32'(reqReady), 32'(3'b001));
    cyc();
    drive(3'b001, 3'b000, 7, 0, 0, 0, 0, 0);
    #2 chk("mid rd reqReady", 32'(reqReady), 32'(3'b001));
    cyc();
    idle();
    #2 chk("mid wr respValid", 32'(respValid), 32'(3'b001));
    chk("mid wr respOut", 32'(respOut), 77);
    reset = 1'b0;
    #1 chk("mid rst respValid0", 32'(respValid), 0);
    cyc();
    chk("mid rst respValid1", 32'(respValid), 0);
    cyc();
    reset = 1'b1;
    #2 chk("mid rel respValid", 32'(respValid), 0);
    cyc();
    drive(3'b001, 3'b000, 7, 0, 0, 0, 0, 0);
    #2 chk("mid rerd reqReady", 32'(reqReady), 32'(3'b001));
    cyc();
    idle();
    #2 chk("mid rerd gap respValid", 32'(respValid), 0);
    cyc();
    #2 chk("mid rerd respValid", 32'(respValid), 32'(3'b001));
    chk("mid rerd respOut", 32'(respOut), 77);
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
